pwm_generator: RTL and testbench
================================

// Module: pwm_generator
// PURPOSE
//   Motor-side end of the pwm_update/pwm_ratio/pwm_done handshake driven by the PID controller.
//   Turns an 8-bit duty request plus direction into a registered PWM waveform and direction pin.
//   A new ratio is applied only at a PWM period boundary, and each application is acknowledged
//   with a pwm_done pulse. A reversal of direction at nonzero duty inserts a dead-time with the
//   output held low.
// PARAMETERS
//   PRESCALE    4'd? -> 16   clock cycles per PWM tick (>=1); period = 255 ticks
//   DEAD_TICKS  16'd255       ticks of forced-low output on a direction reversal (>=1)
// PORTS
//   clock          in   1  main clock
//   reset_n        in   1  asynchronous active-low reset
//   pwm_enable     in   1  run enable; low forces IDLE
//   pwm_update     in   1  level request: apply pwm_ratio/pwm_direction at next boundary
//   pwm_ratio      in   8  requested high-time out of 255
//   pwm_direction  in   1  requested motor direction
//   pwm_done       out  1  1-cycle pulse: requested ratio now active
//   pwm_signal     out  1  PWM output to motor driver (registered)
//   pwm_dir_out    out  1  active direction to motor driver (registered)
//   active_ratio   out  8  ratio currently applied (for debug_signals)
// BEHAVIOUR
//   Reset: pwm_done=0, pwm_signal=0, pwm_dir_out=0, active_ratio=0, state=IDLE, counters=0.
//   Counters: prescale_cnt 0..PRESCALE-1. tick = (prescale_cnt==PRESCALE-1).
//     period_cnt 8b counts 0..254 on tick, then wraps to 0. boundary = tick && period_cnt==254.
//   Output: pwm_signal <= (state==RUN) && (period_cnt_next < active_ratio_next).
//     ratio 0 -> constant low; ratio 255 -> constant high. Uses the values the counters and ratio take after this edge.
//   States:
//     IDLE: pwm_signal=0, active_ratio=0, counters held 0.
//       pwm_enable=1 -> RUN, with prescale_cnt=PRESCALE-1 and period_cnt=254.
//       The first RUN cycle is therefore a boundary.
//     RUN: at a boundary with pwm_update=1:
//       - same direction (pwm_direction==pwm_dir_out), or active_ratio==0:
//         active_ratio <= pwm_ratio, pwm_dir_out <= pwm_direction, pwm_done=1 on the next cycle only.
//       - reversal with active_ratio!=0:
//         -> DEAD, active_ratio <= 0, pending ratio and direction latched, no pwm_done.
//       At a boundary with pwm_update=0: hold active_ratio, no pwm_done.
//       pwm_update=1 between boundaries: no effect until the next boundary (ratio sampled only at the boundary).
//     DEAD: pwm_signal=0; dead_cnt counts ticks.
//       After DEAD_TICKS ticks: pwm_dir_out <= pending dir, active_ratio <= pending ratio,
//       period_cnt=0, pwm_done pulse, -> RUN. Inputs are ignored during DEAD.
//   pwm_enable=0 in RUN or DEAD: next cycle IDLE, pwm_signal=0, active_ratio=0.
//     Any pending ratio is dropped with no pwm_done. pwm_dir_out holds its value.
//     pwm_enable low has priority over a simultaneous boundary or dead-time expiry.
//   pwm_done is never high for two consecutive cycles and is never asserted in IDLE.
//   Asynchronous reset mid-period or mid-DEAD returns immediately to the reset values.
// TESTING (PRESCALE=4, DEAD_TICKS=8)
//   1. enable=1, update=1, ratio=64, dir=0 -> pwm_done 1 cycle after the first RUN cycle.
//      pwm_signal high 256 cycles, low 764 cycles, period 1020.
//   2. Mid-period change to ratio=200 -> old duty holds to the boundary.
//      Then exactly one pwm_done and high 800 cycles per period; update=0 -> no further done.
//   3. ratio=0 -> pwm_signal never high; ratio=255 -> pwm_signal constant high across the boundary.
//   4. Running ratio=128 dir=0, request dir=1 ratio=100 -> at the boundary pwm_signal low for 32 cycles.
//      Then pwm_dir_out=1, pwm_done pulse, high 400 cycles.
//   5. Drop pwm_enable mid-period and mid-DEAD -> pwm_signal=0 next cycle, active_ratio=0, no pwm_done.
//      Re-enable restarts with an immediate boundary.
//   6. Assert reset_n=0 mid-period -> all outputs 0 asynchronously.
//      After release, state IDLE until pwm_enable=1.

Source files
------------

// File: rtl/pwm_generator.sv
// -----------------------------------------------------------------------------
// pwm_generator
//
// Motor-side end of the pwm_update / pwm_ratio / pwm_done handshake driven by
// the PID controller. An 8-bit duty request plus a direction becomes a
// registered PWM waveform and a registered direction pin.
//
// Timing:
//   - One PWM tick is PRESCALE clock cycles.
//   - One PWM period is 255 ticks.
//   - A new ratio is applied only at a period boundary, and each application
//     is acknowledged by a one-cycle pwm_done pulse.
//   - A direction reversal while the duty is nonzero inserts a dead-time of
//     DEAD_TICKS ticks with the output held low. The new ratio and direction
//     take effect after the dead-time.
//
// Ports:
//   clock          in   1  main clock
//   reset_n        in   1  asynchronous active-low reset
//   pwm_enable     in   1  run enable; low forces IDLE
//   pwm_update     in   1  level request: apply ratio/direction at next boundary
//   pwm_ratio      in   8  requested high-time out of 255
//   pwm_direction  in   1  requested motor direction
//   pwm_done       out  1  one-cycle pulse: requested ratio now active
//   pwm_signal     out  1  PWM output to motor driver (registered)
//   pwm_dir_out    out  1  active direction to motor driver (registered)
//   active_ratio   out  8  ratio currently applied
// -----------------------------------------------------------------------------
module pwm_generator #(
    parameter int unsigned PRESCALE   = 16,  // clock cycles per PWM tick (>=1)
    parameter int unsigned DEAD_TICKS = 255  // forced-low ticks on reversal (>=1)
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pwm_enable,
    input  logic       pwm_update,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    output logic       pwm_done,
    output logic       pwm_signal,
    output logic       pwm_dir_out,
    output logic [7:0] active_ratio
);

    localparam int unsigned     PS_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST     = PS_W'(PRESCALE - 1);
    localparam logic [7:0]      PERIOD_LAST = 8'd254;
    localparam logic [15:0]     DEAD_LAST   = 16'(DEAD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_e;

    state_e          state_q,      state_d;
    logic [PS_W-1:0] prescale_q,   prescale_d;
    logic [7:0]      period_q,     period_d;
    logic [15:0]     dead_q,       dead_d;
    logic [7:0]      ratio_q,      ratio_d;
    logic            dir_q,        dir_d;
    logic [7:0]      pend_ratio_q, pend_ratio_d;
    logic            pend_dir_q,   pend_dir_d;
    logic            done_q,       done_d;
    logic            signal_q,     signal_d;

    logic tick;
    logic boundary;

    assign tick     = (prescale_q == PS_LAST);
    assign boundary = tick && (period_q == PERIOD_LAST);

    // NOTE: every variable driven here gets a default first. Any path that
    // leaves a variable unassigned would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        period_d     = period_q;
        dead_d       = dead_q;
        ratio_d      = ratio_q;
        dir_d        = dir_q;
        pend_ratio_d = pend_ratio_q;
        pend_dir_d   = pend_dir_q;
        // done defaults low, so it can only ever be a one-cycle pulse.
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                prescale_d = '0;
                period_d   = '0;
                dead_d     = '0;
                ratio_d    = '0;
                if (pwm_enable) begin
                    // Preload the counters to the last tick of a period, so
                    // the first RUN cycle is already a boundary.
                    state_d    = RUN;
                    prescale_d = PS_LAST;
                    period_d   = PERIOD_LAST;
                end
            end

            RUN: begin
                prescale_d = tick ? '0 : prescale_q + 1'b1;
                if (tick) begin
                    period_d = (period_q == PERIOD_LAST) ? 8'd0 : period_q + 8'd1;
                end

                if (!pwm_enable) begin
                    state_d    = IDLE;
                    prescale_d = '0;
                    period_d   = '0;
                    ratio_d    = '0;
                end else if (boundary && pwm_update) begin
                    if ((pwm_direction == dir_q) || (ratio_q == 8'd0)) begin
                        ratio_d = pwm_ratio;
                        dir_d   = pwm_direction;
                        done_d  = 1'b1;
                    end else begin
                        // Reversal under load: park the request and force
                        // the output low for the dead-time.
                        state_d      = DEAD;
                        ratio_d      = '0;
                        pend_ratio_d = pwm_ratio;
                        pend_dir_d   = pwm_direction;
                        dead_d       = '0;
                    end
                end
            end

            DEAD: begin
                prescale_d = tick ? '0 : prescale_q + 1'b1;
                period_d   = '0;
                if (tick) begin
                    dead_d = dead_q + 16'd1;
                end

                if (!pwm_enable) begin
                    state_d    = IDLE;
                    prescale_d = '0;
                    dead_d     = '0;
                    ratio_d    = '0;
                end else if (tick && (dead_q == DEAD_LAST)) begin
                    state_d = RUN;
                    ratio_d = pend_ratio_q;
                    dir_d   = pend_dir_q;
                    dead_d  = '0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d    = IDLE;
                prescale_d = '0;
                period_d   = '0;
                dead_d     = '0;
                ratio_d    = '0;
            end
        endcase

        // The output compare uses the post-edge counter and ratio. This keeps
        // the registered pin aligned with the state it describes.
        signal_d = (state_d == RUN) && (period_d < ratio_d);
    end

    // NOTE: state registers use non-blocking assignments only. Blocking
    // assignments here would make the result depend on block evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            prescale_q   <= '0;
            period_q     <= '0;
            dead_q       <= '0;
            ratio_q      <= '0;
            dir_q        <= 1'b0;
            pend_ratio_q <= '0;
            pend_dir_q   <= 1'b0;
            done_q       <= 1'b0;
            signal_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            period_q     <= period_d;
            dead_q       <= dead_d;
            ratio_q      <= ratio_d;
            dir_q        <= dir_d;
            pend_ratio_q <= pend_ratio_d;
            pend_dir_q   <= pend_dir_d;
            done_q       <= done_d;
            signal_q     <= signal_d;
        end
    end

    assign pwm_done     = done_q;
    assign pwm_signal   = signal_q;
    assign pwm_dir_out  = dir_q;
    assign active_ratio = ratio_q;

endmodule

// File: tb/tb_pwm_generator.sv
// -----------------------------------------------------------------------------
// tb_pwm_generator
//
// Directed bench for pwm_generator with PRESCALE=4 and DEAD_TICKS=8.
//   - One PWM period is 255 * 4 = 1020 cycles.
//   - The dead-time is 32 cycles.
//
// Timing of stimulus and sampling:
//   - Inputs are driven 1 time unit after a rising edge.
//   - Outputs are sampled at that same point, so each sample reflects the
//     edge that has just occurred.
//   - "Sample X" below means the observation taken just after edge X.
// -----------------------------------------------------------------------------
module tb_pwm_generator;

    logic       clock;
    logic       reset_n;
    logic       pwm_enable;
    logic       pwm_update;
    logic [7:0] pwm_ratio;
    logic       pwm_direction;
    logic       pwm_done;
    logic       pwm_signal;
    logic       pwm_dir_out;
    logic [7:0] active_ratio;

    int checks   = 0;
    int failures = 0;
    int highs;
    int dones;

    pwm_generator #(
        .PRESCALE  (4),
        .DEAD_TICKS(8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pwm_enable   (pwm_enable),
        .pwm_update   (pwm_update),
        .pwm_ratio    (pwm_ratio),
        .pwm_direction(pwm_direction),
        .pwm_done     (pwm_done),
        .pwm_signal   (pwm_signal),
        .pwm_dir_out  (pwm_dir_out),
        .active_ratio (active_ratio)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Samples n consecutive cycles and counts high outputs and done pulses.
    // On return the bench sits on the sample n cycles after the start.
    task automatic measure(input int n, output int h, output int d);
        h = 0;
        d = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm_signal) h++;
            if (pwm_done)   d++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        pwm_enable    = 1'b0;
        pwm_update    = 1'b0;
        pwm_ratio     = 8'd0;
        pwm_direction = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_signal", 32'(pwm_signal),   0);
        check("rst_done",   32'(pwm_done),     0);
        check("rst_dir",    32'(pwm_dir_out),  0);
        check("rst_ratio",  32'(active_ratio), 0);
        reset_n = 1'b1;
        repeat (3) step();
        check("idle_signal", 32'(pwm_signal), 0);
        check("idle_done",   32'(pwm_done),   0);

        // ---------------- 1: ratio 64, first boundary ----------------
        pwm_enable    = 1'b1;
        pwm_update    = 1'b1;
        pwm_ratio     = 8'd64;
        pwm_direction = 1'b0;
        step();  // IDLE -> RUN
        check("t1_first_run_done", 32'(pwm_done),     0);
        check("t1_first_run_sig",  32'(pwm_signal),   0);
        step();  // first RUN cycle was a boundary: ratio applied
        check("t1_done",  32'(pwm_done),     1);
        check("t1_ratio", 32'(active_ratio), 64);
        check("t1_sig",   32'(pwm_signal),   1);
        check("t1_dir",   32'(pwm_dir_out),  0);
        pwm_update = 1'b0;
        measure(1020, highs, dones);
        check("t1_high_cycles", 32'(highs), 256);
        check("t1_done_count",  32'(dones), 1);
        check("t1_no_redone",   32'(pwm_done),     0);
        check("t1_hold_ratio",  32'(active_ratio), 64);
        check("t1_wrap_high",   32'(pwm_signal),   1);

        // ---------------- 2: mid-period change to 200 ----------------
        repeat (100) step();
        pwm_ratio  = 8'd200;
        pwm_update = 1'b1;
        measure(920, highs, dones);  // old duty holds: samples 100..255 high
        check("t2_old_duty_high", 32'(highs), 156);
        check("t2_no_early_done", 32'(dones), 0);
        check("t2_done",  32'(pwm_done),     1);
        check("t2_ratio", 32'(active_ratio), 200);
        pwm_update = 1'b0;
        measure(1020, highs, dones);
        check("t2_high_cycles", 32'(highs), 800);
        check("t2_done_count",  32'(dones), 1);
        check("t2_no_redone",   32'(pwm_done), 0);

        // ---------------- 3: ratio 0 and ratio 255 ----------------
        pwm_ratio  = 8'd0;
        pwm_update = 1'b1;
        repeat (1020) step();
        check("t3_zero_done",  32'(pwm_done),     1);
        check("t3_zero_ratio", 32'(active_ratio), 0);
        check("t3_zero_sig",   32'(pwm_signal),   0);
        pwm_update = 1'b0;
        measure(1020, highs, dones);
        check("t3_zero_highs", 32'(highs), 0);
        check("t3_zero_dones", 32'(dones), 1);
        pwm_ratio  = 8'd255;
        pwm_update = 1'b1;
        measure(1020, highs, dones);
        check("t3_zero_highs2", 32'(highs), 0);
        check("t3_full_done",   32'(pwm_done),     1);
        check("t3_full_ratio",  32'(active_ratio), 255);
        pwm_update = 1'b0;
        measure(1030, highs, dones);  // crosses the next boundary
        check("t3_full_highs", 32'(highs), 1030);
        check("t3_full_dones", 32'(dones), 1);

        // ---------------- 4: reversal with dead-time ----------------
        pwm_ratio     = 8'd128;
        pwm_direction = 1'b0;
        pwm_update    = 1'b1;
        repeat (1010) step();
        check("t4_128_done",  32'(pwm_done),     1);
        check("t4_128_ratio", 32'(active_ratio), 128);
        pwm_update = 1'b0;
        repeat (50) step();
        pwm_direction = 1'b1;
        pwm_ratio     = 8'd100;
        pwm_update    = 1'b1;
        repeat (970) step();
        check("t4_dead_sig",   32'(pwm_signal),   0);
        check("t4_dead_ratio", 32'(active_ratio), 0);
        check("t4_dead_done",  32'(pwm_done),     0);
        check("t4_dead_dir",   32'(pwm_dir_out),  0);
        measure(32, highs, dones);
        check("t4_dead_highs", 32'(highs), 0);
        check("t4_dead_dones", 32'(dones), 0);
        check("t4_post_sig",   32'(pwm_signal),   1);
        check("t4_post_done",  32'(pwm_done),     1);
        check("t4_post_dir",   32'(pwm_dir_out),  1);
        check("t4_post_ratio", 32'(active_ratio), 100);
        pwm_update = 1'b0;
        measure(1020, highs, dones);
        check("t4_high_cycles", 32'(highs), 400);
        check("t4_done_count",  32'(dones), 1);

        // ---------------- 5: enable drop mid-period and mid-DEAD ----------------
        repeat (20) step();
        pwm_enable = 1'b0;
        step();
        check("t5_off_sig",   32'(pwm_signal),   0);
        check("t5_off_ratio", 32'(active_ratio), 0);
        check("t5_off_done",  32'(pwm_done),     0);
        check("t5_off_dir",   32'(pwm_dir_out),  1);
        measure(10, highs, dones);
        check("t5_off_highs", 32'(highs), 0);
        pwm_enable    = 1'b1;
        pwm_update    = 1'b1;
        pwm_ratio     = 8'd100;
        pwm_direction = 1'b1;
        step();
        check("t5_re_run_done", 32'(pwm_done), 0);
        step();
        check("t5_re_done",  32'(pwm_done),     1);
        check("t5_re_ratio", 32'(active_ratio), 100);
        pwm_direction = 1'b0;
        pwm_ratio     = 8'd50;
        repeat (1020) step();
        check("t5_dead_ratio", 32'(active_ratio), 0);
        check("t5_dead_sig",   32'(pwm_signal),   0);
        repeat (10) step();
        pwm_enable = 1'b0;
        pwm_update = 1'b0;
        step();
        check("t5_dead_off_sig",  32'(pwm_signal),  0);
        check("t5_dead_off_dir",  32'(pwm_dir_out), 1);
        check("t5_dead_off_done", 32'(pwm_done),    0);
        measure(40, highs, dones);
        check("t5_dropped_dones", 32'(dones), 0);
        pwm_enable    = 1'b1;
        pwm_update    = 1'b1;
        pwm_ratio     = 8'd30;
        pwm_direction = 1'b0;
        step();
        check("t5_re2_run_done", 32'(pwm_done), 0);
        step();  // zero active ratio: reversal applies directly, no dead-time
        check("t5_re2_done",  32'(pwm_done),     1);
        check("t5_re2_ratio", 32'(active_ratio), 30);
        check("t5_re2_dir",   32'(pwm_dir_out),  0);
        pwm_update = 1'b0;

        // ---------------- 6: asynchronous reset mid-period ----------------
        repeat (50) step();
        check("t6_pre_sig", 32'(pwm_signal), 1);
        reset_n = 1'b0;
        #2;
        check("t6_async_sig",   32'(pwm_signal),   0);
        check("t6_async_ratio", 32'(active_ratio), 0);
        check("t6_async_done",  32'(pwm_done),     0);
        check("t6_async_dir",   32'(pwm_dir_out),  0);
        pwm_enable = 1'b0;
        step();
        reset_n = 1'b1;
        measure(20, highs, dones);
        check("t6_idle_highs", 32'(highs), 0);
        check("t6_idle_dones", 32'(dones), 0);
        pwm_enable    = 1'b1;
        pwm_update    = 1'b1;
        pwm_ratio     = 8'd10;
        pwm_direction = 1'b1;
        step();
        check("t6_run_done", 32'(pwm_done), 0);
        step();
        check("t6_done",  32'(pwm_done),     1);
        check("t6_ratio", 32'(active_ratio), 10);
        check("t6_dir",   32'(pwm_dir_out),  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
